crc5_word_checker: RTL and testbench
====================================

# crc5_word_checker

Receive-side integrity checker for 32-bit words protected by a 5-bit CRC (polynomial 1+x^2+x^5). Sits behind any link or storage path whose transmit side appends the CRC-5 to each 32-bit word. It recomputes the CRC on each incoming word, compares it with the received check bits, and forwards word, syndrome and error flag downstream through a two-stage valid/ready pipeline. A saturating error counter and a sticky error flag are kept for status readout.

## Interface
- CNT_W, 8, width of the error counter
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  checker can accept a word this cycle
- in_data  in  32  received data word
- in_crc  in  5  received check bits
- out_valid  out  1  checked word available
- out_ready  in  1  downstream accepts the word
- out_data  out  32  data word, unmodified
- out_syndrome  out  5  recomputed CRC XOR in_crc
- out_err  out  1  out_syndrome != 0
- clr_err  in  1  synchronous clear of err_cnt and err_sticky
- err_cnt  out  CNT_W  count of errored words delivered, saturating
- err_sticky  out  1  set by the first errored word delivered; held until clr_err

## Operation
- CRC definition: zero initial state, no reflection, no final XOR. Serial equivalent: s=0; for i=31 down to 0: fb=s[4]^in_data[i]; s={s[3], s[2], s[1]^fb, s[0], fb}. Implement it as a single-cycle parallel XOR network.
- Stage 1 (S1) registers in_data and in_crc on the in_valid&&in_ready transfer.
- Stage 2 (S2) registers out_data, out_syndrome = crc(S1 data) ^ S1 crc, and out_err = |out_syndrome.
- Each stage holds a valid bit. S2 loads when S1 is valid and (S2 is empty or out_ready). S1 loads when in_valid and in_ready.
- in_ready = !s1_valid || s2_can_load, where s2_can_load = !s2_valid || out_ready. Full throughput is one word per cycle with no bubbles.
- The pipeline never drops, duplicates or reorders a word.
- Counting happens on the out_valid && out_ready && out_err transfer: err_cnt increments (saturates at 2^CNT_W-1) and err_sticky sets.
- clr_err takes effect on the next edge. If clr_err coincides with a counted transfer, err_cnt becomes 1 and err_sticky becomes 1, so the new error is not lost.
- Data values do not matter while out_valid=0.

## Timing
- Reset (asynchronous assert, values hold until the first edge after release): s1_valid=0, s2_valid=0, out_valid=0, in_ready=1, out_data=0, out_syndrome=0, out_err=0, err_cnt=0, err_sticky=0.
- Latency is 2 cycles. A word accepted at edge N is presented at out_valid after edge N+1, i.e. it can transfer at edge N+2.
- Backpressure:
  - out_ready low holds S2 stable: out_data, out_syndrome and out_err do not change while out_valid && !out_ready.
  - If S1 is also full, in_ready drops combinationally in that same cycle.
  - in_ready returns high in the cycle out_ready rises, with no extra bubble.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid to out_valid.
- Reset asserted mid-stream discards all in-flight words immediately. Counters clear.

## Test plan
- Known vectors, out_ready=1, in_crc=0:
  - 0x00000000 -> syndrome 0x00, err 0
  - 0x00000001 -> syndrome 0x05
  - 0x00000002 -> syndrome 0x0A
  - 0x80000000 -> syndrome 0x05
  - 0xFFFFFFFF -> syndrome 0x05
  - each of these arrives 2 cycles after acceptance.
- Clean stream: 100 back-to-back random words with correct in_crc -> 100 outputs in order, all err=0, in_ready constantly 1, err_cnt=0.
- Single-bit corruption: flip each of the 32 data bits and each of the 5 CRC bits in turn -> every word err=1, syndrome nonzero, err_cnt=37, err_sticky=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 words are accepted, in_ready=0 after that, and the S2 outputs stay stable.
  - Release out_ready -> all words are delivered in order with none lost.
- Counter edge cases:
  - CNT_W=2, deliver 5 errored words -> err_cnt saturates at 3.
  - clr_err in the same cycle as an errored transfer -> err_cnt=1, err_sticky=1.
  - clr_err alone -> err_cnt=0, err_sticky=0.
- Reset mid-operation: assert rst_n=0 with both stages full and err_cnt=2 -> out_valid=0, in_ready=1 and err_cnt=0 immediately. No stale word appears after release.

Source files
------------

// File: rtl/crc5_word_checker_if.sv
// crc5_word_checker_if: valid/ready bundle between an upstream word source,
// the CRC-5 word checker and its downstream consumer.
//   in_valid/in_ready/in_data/in_crc        : received 32-bit word plus check bits
//   out_valid/out_ready/out_data            : checked word, unmodified
//   out_syndrome/out_err                    : recomputed CRC ^ received CRC, nonzero flag
// master: the environment (drives words, accepts results); slave: the checker.
interface crc5_word_checker_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_crc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_syndrome;
    logic        out_err;
    modport master (
        output in_valid, in_data, in_crc, out_ready,
        input  in_ready, out_valid, out_data, out_syndrome, out_err
    );
    modport slave (
        input  in_valid, in_data, in_crc, out_ready,
        output in_ready, out_valid, out_data, out_syndrome, out_err
    );
endinterface

// File: rtl/crc5_word_checker.sv
// crc5_word_checker: two-stage valid/ready pipeline that recomputes the CRC-5
// (poly 1+x^2+x^5, zero init, no reflection, no final XOR) of each 32-bit word
// and reports the syndrome against the received check bits.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : slave side of crc5_word_checker_if (word in, checked word out)
//   clr_err     : synchronous clear of err_cnt / err_sticky
//   err_cnt     : saturating count of errored words delivered downstream
//   err_sticky  : set by the first errored word delivered, held until clr_err
module crc5_word_checker #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    crc5_word_checker_if.slave   bus,
    input  logic                 clr_err,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 err_sticky
);
    logic        s1_valid, s2_valid;
    logic [31:0] s1_data, s2_data;
    logic [4:0]  s1_crc, s1_calc, s2_syndrome;
    logic        s2_err;
    logic        s2_can_load, s2_load, s1_load, fire;

    // Unrolled serial LFSR; synthesis flattens it into a pure XOR network.
    function automatic logic [4:0] crc5(input logic [31:0] d);
        logic [4:0] s;
        logic       fb;
        s = '0;
        for (int i = 31; i >= 0; i--) begin
            fb = s[4] ^ d[i];
            s  = {s[3], s[2], s[1] ^ fb, s[0], fb};
        end
        return s;
    endfunction

    assign s1_calc          = crc5(s1_data);
    assign s2_can_load      = !s2_valid || bus.out_ready;
    assign s2_load          = s1_valid && s2_can_load;
    assign s1_load          = bus.in_valid && bus.in_ready;
    assign fire             = s2_valid && bus.out_ready && s2_err;
    assign bus.in_ready     = !s1_valid || s2_can_load;
    assign bus.out_valid    = s2_valid;
    assign bus.out_data     = s2_data;
    assign bus.out_syndrome = s2_syndrome;
    assign bus.out_err      = s2_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            s1_data     <= '0;
            s1_crc      <= '0;
            s2_data     <= '0;
            s2_syndrome <= '0;
            s2_err      <= 1'b0;
            err_cnt     <= '0;
            err_sticky  <= 1'b0;
        end else begin
            s1_valid <= s1_load ? 1'b1 : (s2_load ? 1'b0 : s1_valid);
            s2_valid <= s2_load ? 1'b1 : (bus.out_ready ? 1'b0 : s2_valid);
            if (s1_load) begin
                s1_data <= bus.in_data;
                s1_crc  <= bus.in_crc;
            end
            if (s2_load) begin
                s2_data     <= s1_data;
                s2_syndrome <= s1_calc ^ s1_crc;
                s2_err      <= |(s1_calc ^ s1_crc);
            end
            // A clear that coincides with a counted error keeps that error.
            if (clr_err)
                err_cnt <= fire ? CNT_W'(1) : '0;
            else if (fire && err_cnt != {CNT_W{1'b1}})
                err_cnt <= err_cnt + CNT_W'(1);
            err_sticky <= clr_err ? fire : (err_sticky | fire);
        end
    end
endmodule

// File: tb/tb_crc5_word_checker.sv
// tb_crc5_word_checker: directed/randomized bench for crc5_word_checker.
// Reference CRC is polynomial long division of d*x^5 by x^5+x^2+1; the
// pipeline is modelled as an in-order queue of accepted words with their
// acceptance cycle. A second instance with CNT_W=2 shares the stimulus.
module tb_crc5_word_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clr_err = 1'b0;
    always #5 clk = ~clk;

    crc5_word_checker_if bus ();
    crc5_word_checker_if bus2 ();
    logic [7:0] err_cnt;
    logic       err_sticky;
    logic [1:0] err_cnt2;
    logic       err_sticky2;

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_data   = bus.in_data;
    assign bus2.in_crc    = bus.in_crc;
    assign bus2.out_ready = bus.out_ready;

    crc5_word_checker #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .clr_err(clr_err),
        .err_cnt(err_cnt), .err_sticky(err_sticky)
    );
    crc5_word_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .clr_err(clr_err),
        .err_cnt(err_cnt2), .err_sticky(err_sticky2)
    );

    typedef struct {
        logic [31:0] d;
        logic [4:0]  c;
        int          cyc;
        int          ks;
    } word_t;

    word_t q[$];
    int checks = 0, errors = 0, cyc = 0, acc_n = 0, kexp = -1;
    int cnt = 0, cnt2 = 0;
    bit sticky = 1'b0;

    function automatic logic [4:0] ref_crc(input logic [31:0] d);
        logic [36:0] r;
        r = {d, 5'b0};
        for (int i = 36; i >= 5; i--)
            if (r[i]) r = r ^ (37'h25 << (i - 5));
        return r[4:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs in the low phase, advance the model, then check status.
    task automatic cycle();
        bit ev, er, acc, del, fire;
        logic [4:0] syn;
        word_t w;
        @(negedge clk);
        ev = q.size() > 0 && q[0].cyc < cyc;
        er = !(q.size() >= 2 && !bus.out_ready);
        chk("out_valid", bus.out_valid, ev);
        chk("in_ready", bus.in_ready, er);
        syn = ev ? (ref_crc(q[0].d) ^ q[0].c) : 5'd0;
        if (ev) begin
            chk("out_data", bus.out_data, q[0].d);
            chk("out_syndrome", bus.out_syndrome, syn);
            chk("out_err", bus.out_err, syn != 0);
            if (q[0].ks >= 0) chk("known_syndrome", bus.out_syndrome, q[0].ks);
        end
        acc  = bus.in_valid && er;
        del  = ev && bus.out_ready;
        fire = del && syn != 0;
        if (clr_err) begin
            cnt = fire; cnt2 = fire; sticky = fire;
        end else if (fire) begin
            cnt  = (cnt < 255) ? cnt + 1 : cnt;
            cnt2 = (cnt2 < 3) ? cnt2 + 1 : cnt2;
            sticky = 1'b1;
        end
        if (del) void'(q.pop_front());
        w = '{bus.in_data, bus.in_crc, 0, kexp};
        @(posedge clk);
        cyc++;
        if (acc) begin
            w.cyc = cyc;
            q.push_back(w);
            acc_n++;
        end
        #1;
        chk("err_cnt", err_cnt, cnt);
        chk("err_sticky", err_sticky, sticky);
        chk("err_cnt_w2", err_cnt2, cnt2);
        chk("err_sticky_w2", err_sticky2, sticky);
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] c, input int ks);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_crc   = c;
        kexp         = ks;
        cycle();
    endtask

    task automatic send_good();
        logic [31:0] d;
        d = $urandom;
        send(d, ref_crc(d), -1);
    endtask

    task automatic send_bad();
        logic [31:0] d;
        d = $urandom;
        send(d, ref_crc(d) ^ 5'h03, -1);
    endtask

    task automatic drain(input int n);
        bus.in_valid = 1'b0;
        kexp = -1;
        repeat (n) cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] kd[5];
        int          ks[5];
        int          a0;
        logic [31:0] d;
        logic [4:0]  c;
        kd = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0002, 32'h8000_0000, 32'hFFFF_FFFF};
        ks = '{0, 5, 10, 5, 5};
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_crc = '0; bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_out_syndrome", bus.out_syndrome, 5'h0);
        chk("rst_out_err", bus.out_err, 1'b0);
        chk("rst_err_cnt", err_cnt, 8'h0);
        chk("rst_err_sticky", err_sticky, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Known vectors, back-to-back, in_crc = 0
        for (int i = 0; i < 5; i++) send(kd[i], 5'h0, ks[i]);
        drain(3);
        clr_err = 1'b1; cycle(); clr_err = 1'b0;

        // Clean random stream
        for (int i = 0; i < 100; i++) send_good();
        drain(3);
        chk("clean_err_cnt", err_cnt, 8'd0);

        // Single-bit corruption of every data and CRC bit
        for (int k = 0; k < 37; k++) begin
            d = $urandom;
            c = ref_crc(d);
            if (k < 32) d[k] = ~d[k];
            else c[k-32] = ~c[k-32];
            send(d, c, -1);
        end
        drain(3);
        chk("corrupt_err_cnt", err_cnt, 8'd37);
        chk("corrupt_sticky", err_sticky, 1'b1);
        chk("sat_err_cnt_w2", err_cnt2, 2'd3);

        // clr_err alone
        clr_err = 1'b1; cycle(); clr_err = 1'b0;
        chk("clr_err_cnt", err_cnt, 8'd0);
        chk("clr_err_sticky", err_sticky, 1'b0);

        // Backpressure: only two words fit while out_ready is low
        bus.out_ready = 1'b0;
        a0 = acc_n;
        repeat (5) send_good();
        chk("bp_accepted", acc_n - a0, 2);
        bus.out_ready = 1'b1;
        drain(4);

        // clr_err coinciding with an errored transfer
        send_bad(); send_bad();
        drain(3);
        chk("pre_clr_err_cnt", err_cnt, 8'd2);
        bus.out_ready = 1'b0;
        send_bad();
        drain(2);
        bus.out_ready = 1'b1;
        clr_err = 1'b1; cycle(); clr_err = 1'b0;
        chk("clr_fire_err_cnt", err_cnt, 8'd1);
        chk("clr_fire_sticky", err_sticky, 1'b1);

        // Reset mid-operation with both stages full and err_cnt = 2
        clr_err = 1'b1; cycle(); clr_err = 1'b0;
        send_bad(); send_bad();
        drain(3);
        bus.out_ready = 1'b0;
        repeat (3) send_good();
        bus.in_valid = 1'b0;
        chk("pre_rst_err_cnt", err_cnt, 8'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk("mid_rst_in_ready", bus.in_ready, 1'b1);
        chk("mid_rst_err_cnt", err_cnt, 8'd0);
        chk("mid_rst_sticky", err_sticky, 1'b0);
        q.delete();
        cnt = 0; cnt2 = 0; sticky = 1'b0;
        @(posedge clk);
        cyc++;
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        drain(4);
        repeat (3) send_good();
        drain(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
